bcd_digit_encoder: RTL
======================

Name: bcd_digit_encoder

Overview:
Sequential binary-to-BCD encoder (iterative shift-add-3). It is the producing end of the digit interface that the seven-segment display blocks consume. It takes a binary count, such as score, combo or timer seconds, and presents stable, glitch-free BCD digits plus a completion pulse. It sits between the score/combo/timer counters and the segment decoders, and converts one bit per clock.

Parameters:
WIDTH, 14, bit width of binary input value
DIGITS, 4, number of BCD digits produced (output width 4*DIGITS)
MAX_VALUE, 9999, saturation ceiling; must be <= 10^DIGITS-1

Ports:
clk  input  1  system clock (CLOCK_50 domain)
rst  input  1  asynchronous, active-high reset
value  input  WIDTH  binary value to encode
force  input  1  one-cycle pulse; requests re-conversion even if value unchanged
bcd  output  4*DIGITS  BCD digits, digit 0 in bits [3:0], registered
busy  output  1  high while a conversion is in flight
done  output  1  one-cycle pulse when bcd updates
overflow  output  1  registered; high when last converted value > MAX_VALUE

Behaviour:
- Reset (async, any time): state=IDLE, bcd=0, busy=0, done=0, overflow=0, last_value=0, pending=0. A conversion in flight is abandoned and no done pulse is issued.
- States: IDLE, SHIFT, COMMIT.
- IDLE:
  - Trigger at a clock edge = (value != last_value) OR force OR pending.
  - On trigger: capture value into shift register and last_value, clear scratch BCD, clear pending, bit counter = WIDTH-1, go to SHIFT; busy=1 from the next cycle.
  - Comparing against last_value makes the first conversion after reset occur only when value becomes nonzero; bcd=0 is already correct for value 0.
- SHIFT:
  - Each cycle, add 3 to every scratch nibble >= 5, then shift {scratch, shift reg} left by 1.
  - After exactly WIDTH SHIFT cycles, go to COMMIT.
- COMMIT (1 cycle):
  - If captured value > MAX_VALUE: bcd = MAX_VALUE in BCD (saturate), overflow=1.
  - Otherwise: bcd = scratch, overflow=0.
  - done=1 for exactly this one cycle after the registered update. busy falls with done. Return to IDLE.
- Latency: value change sampled at edge N → bcd/done valid after edge N+WIDTH+1 (15 cycles for WIDTH=14). Back-to-back conversions: next trigger is accepted in the cycle after done, so throughput is 1 per WIDTH+2 cycles.
- Mid-conversion changes: if value != last_value, or force, occurs while busy, set pending=1. Do not restart. The conversion in flight completes and commits (bcd is never torn). pending then triggers one further conversion of the then-current value. Multiple changes collapse to one pending conversion.
- bcd holds its value between commits; it changes only on the COMMIT edge or reset.
- Scratch width is 4*DIGITS bits. Add-3 is applied to all DIGITS nibbles every SHIFT cycle. Bits shifted out of the top are discarded; saturation handles any overflow.

Optional Feature:
Macro BCD_LEADING_BLANK_EN.
- Defined:
  - Adds output blank[DIGITS-1:0], registered on COMMIT, reset 0.
  - blank[i]=1 when digit i and all higher digits are zero, for i>=1.
  - blank[0] is always 0, so value 0 shows a single "0".
  - Segment decoders use blank to turn segments off.
- Not defined: port is absent; no extra logic.

Test Plan:
- Reset, then value=9999 → busy=1 on the next cycle; done pulses 15 cycles after the value edge; bcd=16'h9999, overflow=0.
- value=305 after the previous conversion completes → bcd=16'h0305. With BCD_LEADING_BLANK_EN: blank=4'b1000.
- value=12000 (> MAX_VALUE) → bcd=16'h9999, overflow=1. Then value=42 → bcd=16'h0042, overflow=0.
- value=100; 5 cycles later value=200; 3 cycles later value=250 → first done with bcd=16'h0100; exactly one further conversion; second done with bcd=16'h0250; no third done.
- force pulse while IDLE with value unchanged at 77 → one conversion; done pulses; bcd stays 16'h0077.
- Assert rst for 1 cycle mid-SHIFT of value=8888 → bcd=0, busy=0 immediately (async), no done pulse. After release with value still 8888, a conversion runs and bcd=16'h8888.

Source files
------------

// File: rtl/bcd_digit_encoder.sv
// Iterative shift-add-3 binary-to-BCD encoder, one input bit per clock, with saturation.
// Optional macro BCD_LEADING_BLANK_EN adds a registered leading-zero blank mask output.
module bcd_digit_encoder #(
    parameter int WIDTH     = 14,
    parameter int DIGITS    = 4,
    parameter int MAX_VALUE = 9999
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      value,
    input  logic                  force_req,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
`ifdef BCD_LEADING_BLANK_EN
    ,
    output logic [DIGITS-1:0]     blank
`endif
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    function automatic logic [BW-1:0] to_bcd(input int unsigned v);
        logic [BW-1:0] r;
        int unsigned   t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    localparam logic [BW-1:0] MAX_BCD = to_bcd(MAX_VALUE);
    // A ceiling the input can never exceed simply disables saturation.
    localparam logic [WIDTH:0] MAX_CMP =
        (longint'(MAX_VALUE) >= (longint'(1) << WIDTH)) ? {1'b0, {WIDTH{1'b1}}}
                                                         : (WIDTH+1)'(MAX_VALUE);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t          state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] last_value;
    logic [BW-1:0]    scratch;
    logic [BW-1:0]    adj;
    logic [BW-1:0]    shifted;
    logic [BW-1:0]    commit_bcd;
    logic [CW-1:0]    cnt;
    logic             pending;
    logic             changed;
    logic             trigger;
    logic             ovf_next;
    logic             unused_msb;

    always_comb begin
        changed = (value != last_value) || force_req;
        trigger = changed || pending;
    end

    always_comb begin
        adj = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
        {unused_msb, shifted} = {adj, shreg[WIDTH-1]};
    end

    // last_value doubles as the captured operand during a conversion.
    always_comb begin
        ovf_next   = {1'b0, last_value} > MAX_CMP;
        commit_bcd = ovf_next ? MAX_BCD : scratch;
    end

`ifdef BCD_LEADING_BLANK_EN
    logic [DIGITS-1:0] blank_next;
    always_comb begin
        logic run;
        run        = 1'b1;
        blank_next = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            run           = run && (commit_bcd[4*i +: 4] == 4'd0);
            blank_next[i] = run;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            last_value <= '0;
            scratch    <= '0;
            cnt        <= '0;
            pending    <= 1'b0;
            bcd        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
`ifdef BCD_LEADING_BLANK_EN
            blank      <= '0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    busy <= trigger;
                    if (trigger) begin
                        shreg      <= value;
                        last_value <= value;
                        scratch    <= '0;
                        pending    <= 1'b0;
                        cnt        <= CW'(WIDTH - 1);
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (changed) pending <= 1'b1;
                    scratch <= shifted;
                    shreg   <= shreg << 1;
                    if (cnt == '0) begin
                        state <= COMMIT;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                COMMIT: begin
                    if (changed) pending <= 1'b1;
                    bcd      <= commit_bcd;
                    overflow <= ovf_next;
`ifdef BCD_LEADING_BLANK_EN
                    blank    <= blank_next;
`endif
                    done     <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
